shifter_iter: RTL and testbench
===============================

SHIFTER_ITER -- requirements
Module: shifter_iter

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits, minimum 8.
REQ-002 Parameter STEP, default 8: maximum bit positions shifted per cycle, 1..WIDTH.
REQ-003 Parameter AMT_W, default 8: width of the shift-amount input.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low: clk, input, 1, rising-edge clock.
REQ-005 The block SHALL provide this port: rst_n, input, 1, asynchronous active-low reset.
REQ-006 The block SHALL provide these inputs: in_valid, input, 1, request present; in_ready, output, 1, request accepted when high with in_valid.
REQ-007 The block SHALL provide this input: rm, input, WIDTH, operand.
REQ-008 The block SHALL provide this input: amount, input, AMT_W, shift amount (only low 5 bits used when reg_mode=0).
REQ-009 The block SHALL provide these inputs: shift, input, 2, type (00 LSL, 01 LSR, 10 ASR, 11 ROR); reg_mode, input, 1, 0 = immediate encoding, 1 = register encoding.
REQ-010 The block SHALL provide these inputs: carry_in, input, 1, current C flag; abort, input, 1, synchronous cancel.
REQ-011 The block SHALL provide these outputs: y, output, WIDTH, result; carry_out, output, 1, shifter carry.
REQ-012 The block SHALL provide these handshake ports: out_valid, output, 1, result valid; out_ready, input, 1, consumer accepts.

Function
REQ-013 The FSM SHALL have three states, IDLE, SHIFT and DONE, and in_ready SHALL be 1 only in IDLE.
REQ-014 On accept, the block SHALL capture rm, carry_in, shift and a normalised count n, then enter SHIFT if n>0 and DONE otherwise.
REQ-015 In immediate mode, amount 0 SHALL be treated as: LSL, no shift, carry=carry_in; LSR/ASR, n=WIDTH; ROR, RRX, meaning y={carry_in,rm[W-1:1]} and carry=rm[0], with n=0.
REQ-016 In register mode, amount 0 SHALL give y=rm and carry=carry_in, with n=0.
REQ-017 For LSL/LSR with amount >WIDTH, the block SHALL force y=0 and carry 0, with n=WIDTH.
REQ-018 For LSL/LSR with amount ==WIDTH, y SHALL be 0 and carry SHALL be rm[0] (LSL) or rm[W-1] (LSR).
REQ-019 For ASR with amount >=WIDTH, y SHALL be all copies of rm[W-1] and carry SHALL be rm[W-1], with n=WIDTH.
REQ-020 For ROR in register mode, n SHALL equal amount mod WIDTH; if amount is nonzero and n=0, y=rm and carry=rm[W-1].
REQ-021 Each SHIFT cycle SHALL shift the working register by k=min(STEP,remaining) and set carry to the last bit shifted out, and after k bits remaining SHALL decrease by k.
REQ-022 When remaining reaches 0, the FSM SHALL go to DONE, and out_valid SHALL assert after exactly ceil(n/STEP) clock edges following the accept edge (the same edge when n=0).
REQ-023 In DONE, y, carry_out and out_valid SHALL be held stable until out_ready=1, after which the FSM returns to IDLE on that edge.
REQ-024 When abort=1, the FSM SHALL return to IDLE on the next edge from any state and drop out_valid, with no result delivered; abort SHALL override a simultaneous in_valid or out_ready.
REQ-025 Inputs other than in_valid and abort SHALL be ignored outside the accept cycle, and changes mid-operation SHALL have no effect.

Reset
REQ-026 While rst_n=0, the state SHALL be IDLE, in_ready SHALL be 1 once released, and out_valid, y and carry_out SHALL be 0.
REQ-027 When reset is asserted mid-SHIFT or in DONE, the in-flight operation SHALL be discarded immediately and asynchronously.

Structure
REQ-028 A shared package SHALL hold the shift-type encodings (LSL/LSR/ASR/ROR), the FSM state enumeration and the count-normalisation function.
REQ-029 One sub-module, shifter_step, SHALL be provided: a combinational single-step shifter by 0..STEP positions with carry, instantiated once.

Verification (WIDTH=32, STEP=8)
REQ-030 Immediate LSL amount 4, rm=0x0000000A, carry_in=1 -> y=0x000000A0, carry 0, out_valid 1 edge after accept.
REQ-031 Immediate ROR amount 0, rm=0x00000001, carry_in=1 -> y=0x80000000, carry 1, out_valid on the accept edge.
REQ-032 Register LSR, rm=0xFFFFFFFF: amount 32 -> y=0, carry 1, 4 edges; amount 33 -> y=0, carry 0, 4 edges.
REQ-033 Immediate ASR amount 0, rm=0x80000000 -> y=0xFFFFFFFF, carry 1; register ROR amount 36, rm=0x0000000F -> y=0xF0000000, carry 1.
REQ-034 Hold out_ready=0 for 3 cycles in DONE -> y and out_valid stable and in_ready 0; then assert abort together with out_ready -> IDLE, no handshake completes.
REQ-035 Pulse rst_n low during SHIFT of a register LSL by 20 -> out_valid 0 immediately, IDLE, and the next request is processed correctly.

Source files
------------

// File: rtl/shifter_iter_pkg.sv
// rtl/shifter_iter_pkg.sv - shared shift types, FSM states and count normalisation for shifter_iter
// Holds the shift-type encodings, the FSM state enumeration and the function
// that maps a raw shift amount onto the number of single-bit positions the
// iterative datapath must walk through.
package shifter_iter_pkg;

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } shift_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    // Immediate encodings only carry a 5-bit amount.
    localparam int IMM_AMT_W = 5;

    // Number of bit positions to iterate. Amount 0 in immediate mode means a
    // full-width shift for LSR/ASR; LSL/LSR/ASR saturate at width; rotates
    // wrap modulo width (a zero result is resolved at accept time).
    function automatic int norm_count(input int amt, input shift_t sh,
                                      input logic reg_mode, input int width);
        int n;
        if (amt == 0) begin
            n = (!reg_mode && (sh == SH_LSR || sh == SH_ASR)) ? width : 0;
        end else if (sh == SH_ROR) begin
            n = amt % width;
        end else begin
            n = (amt > width) ? width : amt;
        end
        return n;
    endfunction

endpackage

// File: rtl/shifter_step.sv
// rtl/shifter_step.sv - combinational single-step shifter by 0..STEP positions with carry
// Ports:
//   data      - value to shift
//   k         - positions to shift this step (0 passes data and carry through)
//   sh        - shift type
//   carry_in  - carry returned when k is 0
//   data_out  - shifted value
//   carry_out - last bit shifted out (for ROR, the new msb)
module shifter_step
    import shifter_iter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 8,
    parameter int K_W   = $clog2(STEP + 1)
) (
    input  logic [WIDTH-1:0] data,
    input  logic [K_W-1:0]   k,
    input  shift_t           sh,
    input  logic             carry_in,
    output logic [WIDTH-1:0] data_out,
    output logic             carry_out
);

    // Widened by one bit so the carry falls out of the shift itself.
    logic [WIDTH:0]   lsl_wide;
    logic [WIDTH:0]   lsr_wide;
    logic [WIDTH:0]   asr_wide;
    logic [WIDTH-1:0] ror_val;

    always_comb begin
        lsl_wide  = {1'b0, data} << k;
        lsr_wide  = {data, 1'b0} >> k;
        asr_wide  = $signed({data, 1'b0}) >>> k;
        ror_val   = WIDTH'({data, data} >> k);
        data_out  = data;
        carry_out = carry_in;
        if (k != '0) begin
            case (sh)
                SH_LSL: begin
                    data_out  = lsl_wide[WIDTH-1:0];
                    carry_out = lsl_wide[WIDTH];
                end
                SH_LSR: begin
                    data_out  = lsr_wide[WIDTH:1];
                    carry_out = lsr_wide[0];
                end
                SH_ASR: begin
                    data_out  = asr_wide[WIDTH:1];
                    carry_out = asr_wide[0];
                end
                default: begin
                    data_out  = ror_val;
                    carry_out = ror_val[WIDTH-1];
                end
            endcase
        end
    end

endmodule

// File: rtl/shifter_iter.sv
// rtl/shifter_iter.sv - iterative barrel-shifter replacement shifting up to STEP bits per cycle
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   in_valid, in_ready  - request handshake (in_ready only in IDLE)
//   rm, amount, shift   - operand, shift amount, shift type
//   reg_mode            - 0 immediate encoding, 1 register encoding
//   carry_in            - current C flag
//   abort               - synchronous cancel, wins over every handshake
//   y, carry_out        - result and shifter carry
//   out_valid, out_ready- result handshake
module shifter_iter
    import shifter_iter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 8,
    parameter int AMT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] rm,
    input  logic [AMT_W-1:0] amount,
    input  logic [1:0]       shift,
    input  logic             reg_mode,
    input  logic             carry_in,
    input  logic             abort,
    output logic [WIDTH-1:0] y,
    output logic             carry_out,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int K_W   = $clog2(STEP + 1);
    localparam logic [CNT_W-1:0] STEP_CNT = CNT_W'(STEP);

    state_t           state;
    logic [WIDTH-1:0] work;
    logic             carry;
    logic [CNT_W-1:0] rem;
    shift_t           sh;

    shift_t           shift_in;
    int               amt_eff;
    int               n_int;
    logic [CNT_W-1:0] n_acc;
    logic [WIDTH-1:0] load_work;
    logic             load_carry;

    logic [CNT_W-1:0] k_cnt;
    logic [K_W-1:0]   k_step;
    logic [WIDTH-1:0] step_data;
    logic             step_carry;

    // Accept-time decode: count plus the cases that finish with no iteration
    // or need the operand preconditioned.
    always_comb begin
        shift_in   = shift_t'(shift);
        amt_eff    = reg_mode ? int'(amount) : int'(amount[IMM_AMT_W-1:0]);
        n_int      = norm_count(amt_eff, shift_in, reg_mode, WIDTH);
        n_acc      = CNT_W'(n_int);
        load_work  = rm;
        load_carry = carry_in;
        if ((shift_in == SH_LSL || shift_in == SH_LSR) && amt_eff > WIDTH) begin
            // Shifting zeros by WIDTH yields y=0 and carry=0 with no special case.
            load_work = '0;
        end else if (shift_in == SH_ROR && amt_eff == 0 && !reg_mode) begin
            // RRX: rotate right by one through the carry.
            load_work  = {carry_in, rm[WIDTH-1:1]};
            load_carry = rm[0];
        end else if (shift_in == SH_ROR && amt_eff != 0 && n_int == 0) begin
            // Rotate by a multiple of WIDTH: value unchanged, carry is msb.
            load_carry = rm[WIDTH-1];
        end
    end

    always_comb begin
        k_cnt  = (rem < STEP_CNT) ? rem : STEP_CNT;
        k_step = K_W'(k_cnt);
    end

    shifter_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP),
        .K_W   (K_W)
    ) u_step (
        .data      (work),
        .k         (k_step),
        .sh        (sh),
        .carry_in  (carry),
        .data_out  (step_data),
        .carry_out (step_carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            work      <= '0;
            carry     <= 1'b0;
            rem       <= '0;
            sh        <= SH_LSL;
            out_valid <= 1'b0;
        end else if (abort) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        work  <= load_work;
                        carry <= load_carry;
                        rem   <= n_acc;
                        sh    <= shift_in;
                        if (n_acc == '0) begin
                            state     <= ST_DONE;
                            out_valid <= 1'b1;
                        end else begin
                            state <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    work  <= step_data;
                    carry <= step_carry;
                    rem   <= rem - k_cnt;
                    if (rem == k_cnt) begin
                        state     <= ST_DONE;
                        out_valid <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign y         = work;
    assign carry_out = carry;

endmodule

// File: tb/tb_shifter_iter.sv
// tb/tb_shifter_iter.sv - scoreboard bench for shifter_iter with directed and random requests
module tb_shifter_iter;

    localparam int W     = 32;
    localparam int STEP  = 8;
    localparam int AMT_W = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  rm = '0;
    logic [AMT_W-1:0] amount = '0;
    logic [1:0]    shift = '0;
    logic          reg_mode = 1'b0;
    logic          carry_in = 1'b0;
    logic          abort = 1'b0;
    logic [W-1:0]  y;
    logic          carry_out;
    logic          out_valid;
    logic          out_ready = 1'b0;

    always #5 clk = ~clk;

    shifter_iter #(.WIDTH(W), .STEP(STEP), .AMT_W(AMT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .rm        (rm),
        .amount    (amount),
        .shift     (shift),
        .reg_mode  (reg_mode),
        .carry_in  (carry_in),
        .abort     (abort),
        .y         (y),
        .carry_out (carry_out),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    typedef struct {
        logic [31:0] ey;
        logic        ec;
        int          lat;
        int          acc;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic hold_ready = 1'b0;
    logic prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    // Reference: direct closed-form result of each shift rule.
    function automatic void ref_model(input logic [31:0] r, input logic [7:0] amt_i,
                                      input logic [1:0] sh, input logic mode, input logic cin,
                                      output logic [31:0] ey, output logic ec, output int n);
        int a;
        int i;
        a  = mode ? int'(amt_i) : int'(amt_i & 8'h1f);
        ey = r;
        ec = cin;
        n  = 0;
        if (a == 0) begin
            if (!mode) begin
                case (sh)
                    2'd1: begin ey = 32'h0; ec = r[31]; n = 32; end
                    2'd2: begin ey = {32{r[31]}}; ec = r[31]; n = 32; end
                    2'd3: begin ey = {cin, r[31:1]}; ec = r[0]; end
                    default: ;
                endcase
            end
        end else begin
            case (sh)
                2'd0: begin
                    n = (a > 32) ? 32 : a;
                    if (a < 32) begin ey = r << a; ec = r[32 - a]; end
                    else begin ey = 32'h0; ec = (a == 32) ? r[0] : 1'b0; end
                end
                2'd1: begin
                    n = (a > 32) ? 32 : a;
                    if (a < 32) begin ey = r >> a; ec = r[a - 1]; end
                    else begin ey = 32'h0; ec = (a == 32) ? r[31] : 1'b0; end
                end
                2'd2: begin
                    n = (a > 32) ? 32 : a;
                    if (a < 32) begin ey = $signed(r) >>> a; ec = r[a - 1]; end
                    else begin ey = {32{r[31]}}; ec = r[31]; end
                end
                default: begin
                    i = a % 32;
                    n = i;
                    if (i == 0) begin
                        ec = r[31];
                    end else begin
                        ey = (r >> i) | (r << (32 - i));
                        ec = ey[31];
                    end
                end
            endcase
        end
    endfunction

    // Called aligned 1 time unit after a rising edge.
    task automatic send(input logic [31:0] r, input logic [7:0] amt, input logic [1:0] sh,
                        input logic mode, input logic cin, input logic [31:0] ey,
                        input logic ec, input int lat, input string name);
        int guard;
        guard = 0;
        while (!in_ready && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL %s_in_ready_timeout: in_ready 0 required 1", name);
        end else begin
            rm = r; amount = amt; shift = sh; reg_mode = mode; carry_in = cin;
            in_valid = 1'b1;
            @(posedge clk); #1;
            sb.push_back('{ey, ec, lat, cyc, name});
            in_valid = 1'b0;
            // Scramble inputs: they must not matter once accepted.
            rm = $urandom; amount = AMT_W'($urandom); shift = 2'($urandom);
            reg_mode = 1'($urandom); carry_in = 1'($urandom);
        end
    endtask

    task automatic send_rand(input string name);
        logic [31:0] r;
        logic [7:0]  a;
        logic [1:0]  sh;
        logic        mode, cin, ec;
        logic [31:0] ey;
        int          n;
        r    = $urandom;
        sh   = 2'($urandom);
        mode = 1'($urandom);
        cin  = 1'($urandom);
        case ($urandom_range(0, 5))
            0: a = 8'd0;
            1: a = 8'd32;
            2: a = 8'd33;
            3: a = 8'd31;
            4: a = 8'($urandom);
            default: a = 8'($urandom_range(1, 8));
        endcase
        if (!mode) a = a | (8'($urandom) & 8'he0);
        ref_model(r, a, sh, mode, cin, ey, ec, n);
        send(r, a, sh, mode, cin, ey, ec, (n + STEP - 1) / STEP, name);
    endtask

    // Consumer: random backpressure unless a directed test owns out_ready.
    always @(posedge clk) begin
        #1;
        if (!hold_ready) out_ready = ($urandom_range(0, 3) != 0);
    end

    // Monitor: compare every valid cycle, pop on a completed handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
        end else begin
            if (out_valid) begin
                chk("in_ready_low_while_valid", in_ready, 1'b0);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: y 0x%0h with empty scoreboard", y);
                end else begin
                    if (!prev_valid) chk({sb[0].name, "_latency"}, cyc - sb[0].acc, sb[0].lat);
                    chk({sb[0].name, "_y"}, y, sb[0].ey);
                    chk({sb[0].name, "_carry"}, carry_out, sb[0].ec);
                    if (out_ready && !abort) void'(sb.pop_front());
                end
            end
            prev_valid = out_valid;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int g;
        #1;
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_y", y, 32'h0);
        chk("reset_carry", carry_out, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("reset_in_ready", in_ready, 1'b1);

        send(32'h0000000A, 8'd4,  2'd0, 1'b0, 1'b1, 32'h000000A0, 1'b0, 1, "imm_lsl4");
        send(32'h00000001, 8'd0,  2'd3, 1'b0, 1'b1, 32'h80000000, 1'b1, 0, "imm_rrx");
        send(32'hFFFFFFFF, 8'd32, 2'd1, 1'b1, 1'b0, 32'h00000000, 1'b1, 4, "reg_lsr32");
        send(32'hFFFFFFFF, 8'd33, 2'd1, 1'b1, 1'b0, 32'h00000000, 1'b0, 4, "reg_lsr33");
        send(32'h80000000, 8'd0,  2'd2, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b1, 4, "imm_asr0");
        send(32'h0000000F, 8'd36, 2'd3, 1'b1, 1'b0, 32'hF0000000, 1'b1, 1, "reg_ror36");
        send(32'h00000001, 8'd32, 2'd0, 1'b1, 1'b0, 32'h00000000, 1'b1, 4, "reg_lsl32");
        send(32'h80000001, 8'd32, 2'd3, 1'b1, 1'b0, 32'h80000001, 1'b1, 0, "reg_ror32");
        send(32'h7FFFFFFF, 8'd40, 2'd2, 1'b1, 1'b1, 32'h00000000, 1'b0, 4, "reg_asr40");
        send(32'h12345678, 8'd0,  2'd1, 1'b1, 1'b1, 32'h12345678, 1'b1, 0, "reg_amt0");
        send(32'h80000000, 8'hE0, 2'd1, 1'b0, 1'b0, 32'h00000000, 1'b1, 4, "imm_lsr0_hibits");
        send(32'hDEADBEEF, 8'h20, 2'd0, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 0, "imm_lsl0_hibits");
        send(32'h80000000, 8'd1,  2'd0, 1'b1, 1'b0, 32'h00000000, 1'b1, 1, "reg_lsl1");
        send(32'h12345678, 8'd12, 2'd3, 1'b1, 1'b1, 32'h67812345, 1'b0, 2, "reg_ror12");
        send(32'h80000040, 8'd7,  2'd2, 1'b1, 1'b0, 32'hFF000000, 1'b1, 1, "reg_asr7");

        // Hold in DONE, then abort together with out_ready.
        g = 0;
        while (sb.size() != 0 && g < 500) begin @(posedge clk); #1; g++; end
        chk("directed_drain", sb.size(), 0);
        hold_ready = 1'b1;
        out_ready  = 1'b0;
        send(32'h00001234, 8'd20, 2'd0, 1'b1, 1'b0, 32'h23400000, 1'b1, 3, "hold_lsl20");
        g = 0;
        while (!out_valid && g < 20) begin @(posedge clk); #1; g++; end
        chk("hold_valid_seen", out_valid, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("hold_out_valid", out_valid, 1'b1);
            chk("hold_in_ready", in_ready, 1'b0);
            chk("hold_y", y, 32'h23400000);
        end
        abort     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        abort     = 1'b0;
        out_ready = 1'b0;
        chk("abort_out_valid", out_valid, 1'b0);
        chk("abort_in_ready", in_ready, 1'b1);
        chk("abort_no_handshake", sb.size(), 1);
        sb.delete();
        hold_ready = 1'b0;

        // Asynchronous reset in the middle of SHIFT.
        send(32'h000000FF, 8'd20, 2'd0, 1'b1, 1'b1, 32'h0FF00000, 1'b0, 3, "rst_lsl20");
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_out_valid", out_valid, 1'b0);
        chk("rst_mid_in_ready", in_ready, 1'b1);
        chk("rst_mid_y", y, 32'h0);
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send(32'h000000FF, 8'd20, 2'd0, 1'b1, 1'b1, 32'h0FF00000, 1'b0, 3, "post_rst_lsl20");

        for (int i = 0; i < 200; i++) send_rand($sformatf("rand%0d", i));

        g = 0;
        while (sb.size() != 0 && g < 500) begin @(posedge clk); #1; g++; end
        chk("final_drain", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
